mcu32x_dmem_ctrl: RTL

Data-memory controller directly downstream of the MCU32X core. It consumes the core's memory request (address, mem_read, mem_write, write data, byte enables) and serves each request from a word-organised on-chip RAM or a small MMIO register window. Every access gets a fixed, parameterised wait-state latency and completes with a one-cycle ready/err response. Bus errors are flagged rather than silently dropped.

---
 rtl/mcu32x_dmem_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mcu32x_dmem_ctrl.sv
// mcu32x_dmem_ctrl: data-memory controller behind the MCU32X core.
// Serves word RAM and a two-register MMIO window (cycle counter, LED).
// Every access takes a fixed WAIT_STATES latency and ends in a one-cycle
// ready pulse, with err qualifying decode/protocol failures.

// One byte lane of a byte-enabled merge: take the new byte when selected.
module mcu32x_dmem_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module mcu32x_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] led_out,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
  } req_t;

  req_t        req_in, req_q, cur;
  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic [31:0] cyc_cnt, led_q, rdata_q;
  logic        ready_q, err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        misal, hit_ram, hit_cnt, hit_led, bad, do_wr;
  logic [AW-1:0] idx;
  logic [31:0] ram_rd, ram_new, led_new, rd_val;

  assign req_in = '{addr: addr, wdata: wdata, be: be, rd: mem_read, wr: mem_write};
  assign accept = (state == S_IDLE) && (mem_read || mem_write);

  // With zero wait states the accepting edge is also the edge entering RESP,
  // so the live request must be decoded there instead of the latched one.
  assign enter_resp = (accept && (WS == 4'd0)) || ((state == S_WAIT) && (wcnt == 4'd1));
  assign cur        = (state == S_IDLE) ? req_in : req_q;

  assign misal   = |cur.addr[1:0];
  assign hit_ram = cur.addr < RAM_LIMIT;
  assign hit_cnt = cur.addr == MMIO_BASE;
  assign hit_led = cur.addr == (MMIO_BASE + 32'd4);
  assign bad     = misal || !(hit_ram || hit_cnt || hit_led) || (cur.rd && cur.wr) ||
                   (cur.wr && hit_cnt) || (cur.wr && (cur.be == 4'b0000));
  // Gating with reset keeps an aborted transaction from committing.
  assign do_wr   = enter_resp && reset && cur.wr && !bad;

  assign idx    = cur.addr[AW+1:2];
  assign ram_rd = mem[idx];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mcu32x_dmem_lane u_ram_lane (
      .sel(cur.be[i]), .old_b(ram_rd[8*i +: 8]), .new_b(cur.wdata[8*i +: 8]),
      .out_b(ram_new[8*i +: 8])
    );
    mcu32x_dmem_lane u_led_lane (
      .sel(cur.be[i]), .old_b(led_q[8*i +: 8]), .new_b(cur.wdata[8*i +: 8]),
      .out_b(led_new[8*i +: 8])
    );
  end

  // Read-data source select for a decoded read.
  always_comb begin
    rd_val = '0;
    if (hit_ram)      rd_val = ram_rd;
    else if (hit_cnt) rd_val = cyc_cnt;
    else if (hit_led) rd_val = led_q;
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_wr && hit_ram) mem[idx] <= ram_new;
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset) cyc_cnt <= '0;
    else        cyc_cnt <= cyc_cnt + 32'd1;
  end

  // LED register, byte-enabled writes.
  always_ff @(posedge clk) begin
    if (!reset)                  led_q <= '0;
    else if (do_wr && hit_led)   led_q <= led_new;
  end

  // Request FSM plus registered one-cycle response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state)
        S_IDLE: if (accept) begin
          req_q <= req_in;
          wcnt  <= WS;
          state <= (WS == 4'd0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= bad;
        rdata_q <= (bad || cur.wr) ? 32'd0 : rd_val;
      end
    end
  end

  assign ready   = ready_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign led_out = led_q;
  assign busy    = state != S_IDLE;

endmodule
